// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared MIPS opcode/funct/ALU-func definitions
package mips_defs;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_NOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_BAD = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef struct packed {
        logic [2:0] func;
        logic       reg_write;
        logic       dest_rt;
        logic       use_imm;
        logic       zero_ext;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - operand forwarding select, EX/MEM over MEM/WB over regfile
module fwd_mux #(
    parameter int size    = 32,
    parameter int regbits = 5
) (
    input  logic [regbits-1:0] sel_reg,
    input  logic [size-1:0]    reg_data,
    input  logic               exmem_reg_write,
    input  logic [regbits-1:0] exmem_rd,
    input  logic [size-1:0]    exmem_result,
    input  logic               memwb_reg_write,
    input  logic [regbits-1:0] memwb_rd,
    input  logic [size-1:0]    memwb_result,
    output logic [size-1:0]    fwd_data
);

    logic exmem_hit;
    logic memwb_hit;

    // Register 0 is hardwired to zero, so it never receives a forwarded value.
    assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == sel_reg);
    assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == sel_reg);

    always_comb begin
        fwd_data = reg_data;
        if (exmem_hit) begin
            fwd_data = exmem_result;
        end else if (memwb_hit) begin
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU func decode and operand forwarding
module id_ex_stage
    import mips_defs::*;
#(
    parameter int size    = 32,
    parameter int regbits = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [5:0]         id_opcode,
    input  logic [5:0]         id_funct,
    input  logic [15:0]        id_imm,
    input  logic [regbits-1:0] id_rs,
    input  logic [regbits-1:0] id_rt,
    input  logic [regbits-1:0] id_rd,
    input  logic [size-1:0]    id_rs_data,
    input  logic [size-1:0]    id_rt_data,
    input  logic               exmem_reg_write,
    input  logic [regbits-1:0] exmem_rd,
    input  logic [size-1:0]    exmem_result,
    input  logic               memwb_reg_write,
    input  logic [regbits-1:0] memwb_rd,
    input  logic [size-1:0]    memwb_result,
    output logic [size-1:0]    alu_a,
    output logic [size-1:0]    alu_b,
    output logic [2:0]         alu_func,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic [regbits-1:0] ex_dest,
    output logic [size-1:0]    ex_store_data,
    output logic               ex_illegal
);

    function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        dec_t d;
        d      = '0;
        d.func = ALU_BAD;
        case (opcode)
            OP_RTYPE: begin
                d.reg_write = 1'b1;
                case (funct)
                    F_ADD:   d.func = ALU_ADD;
                    F_SUB:   d.func = ALU_SUB;
                    F_AND:   d.func = ALU_AND;
                    F_OR:    d.func = ALU_OR;
                    F_NOR:   d.func = ALU_NOR;
                    F_SLT:   d.func = ALU_SLT;
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                d.func = ALU_ADD; d.reg_write = 1'b1; d.dest_rt = 1'b1; d.use_imm = 1'b1;
            end
            OP_SLTI: begin
                d.func = ALU_SLT; d.reg_write = 1'b1; d.dest_rt = 1'b1; d.use_imm = 1'b1;
            end
            OP_ANDI: begin
                d.func = ALU_AND; d.reg_write = 1'b1; d.dest_rt = 1'b1; d.use_imm = 1'b1;
                d.zero_ext = 1'b1;
            end
            OP_ORI: begin
                d.func = ALU_OR; d.reg_write = 1'b1; d.dest_rt = 1'b1; d.use_imm = 1'b1;
                d.zero_ext = 1'b1;
            end
            OP_LW: begin
                d.func = ALU_ADD; d.reg_write = 1'b1; d.dest_rt = 1'b1; d.use_imm = 1'b1;
            end
            OP_SW: begin
                d.func = ALU_ADD; d.dest_rt = 1'b1; d.use_imm = 1'b1;
            end
            // beq compares two registers; the ALU zero flag resolves it downstream.
            OP_BEQ: begin
                d.func = ALU_SUB; d.dest_rt = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    dec_t               id_dec;
    logic [regbits-1:0] id_dest;
    logic [size-1:0]    id_imm_ext;

    logic [regbits-1:0] ex_rs;
    logic [regbits-1:0] ex_rt;
    logic [size-1:0]    ex_rs_data;
    logic [size-1:0]    ex_rt_data;
    logic [size-1:0]    ex_imm;
    logic               ex_use_imm;
    logic [size-1:0]    rs_fwd;
    logic [size-1:0]    rt_fwd;

    assign id_dec     = decode(id_opcode, id_funct);
    assign id_dest    = id_dec.dest_rt ? id_rt : id_rd;
    assign id_imm_ext = id_dec.zero_ext ? {{(size-16){1'b0}}, id_imm}
                                        : {{(size-16){id_imm[15]}}, id_imm};

    // Bubbles clear only the control bits; the data registers keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_illegal   <= 1'b0;
            alu_func     <= ALU_ADD;
            ex_dest      <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_use_imm   <= 1'b0;
        end else if (flush || (!stall && !id_valid)) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_illegal   <= 1'b0;
            alu_func     <= ALU_ADD;
        end else if (!stall) begin
            ex_valid     <= 1'b1;
            ex_reg_write <= id_dec.reg_write && (id_dest != '0);
            ex_illegal   <= id_dec.illegal;
            alu_func     <= id_dec.func;
            ex_dest      <= id_dest;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_rs_data   <= id_rs_data;
            ex_rt_data   <= id_rt_data;
            ex_imm       <= id_imm_ext;
            ex_use_imm   <= id_dec.use_imm;
        end
    end

    fwd_mux #(.size(size), .regbits(regbits)) u_fwd_rs (
        .sel_reg         (ex_rs),
        .reg_data        (ex_rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (rs_fwd)
    );

    fwd_mux #(.size(size), .regbits(regbits)) u_fwd_rt (
        .sel_reg         (ex_rt),
        .reg_data        (ex_rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (rt_fwd)
    );

    assign alu_a         = rs_fwd;
    assign alu_b         = ex_use_imm ? ex_imm : rt_fwd;
    assign ex_store_data = rt_fwd;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register and operand-select stage that sits directly upstream of the 32-bit ALU in the pipelined MIPS datapath.
- Captures decoded ID-stage fields each cycle and translates opcode/funct into the ALU's 3-bit func code.
- Drives the ALU a/b inputs, including EX/MEM and MEM/WB forwarding.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- size, 32, datapath width
- regbits, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all EX registers this cycle
- flush  in  1  load bubble this cycle
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  6  instruction[31:26]
- id_funct  in  6  instruction[5:0]
- id_imm  in  16  instruction[15:0]
- id_rs, id_rt, id_rd  in  regbits  register indices
- id_rs_data, id_rt_data  in  size  register-file read data
- exmem_reg_write  in  1  EX/MEM will write a register
- exmem_rd  in  regbits  EX/MEM destination
- exmem_result  in  size  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB will write a register
- memwb_rd  in  regbits  MEM/WB destination
- memwb_result  in  size  MEM/WB writeback value
- alu_a, alu_b  out  size  ALU operands (combinational from EX registers)
- alu_func  out  3  ALU func, registered
- ex_valid  out  1  EX holds a real instruction
- ex_reg_write  out  1  EX result is written back
- ex_dest  out  regbits  EX destination register
- ex_store_data  out  size  forwarded rt value for sw
- ex_illegal  out  1  unsupported opcode/funct captured

Behaviour:
- Reset (rst_n low, async): all EX registers are 0; ex_valid=0, ex_reg_write=0, alu_func=3'd0, ex_illegal=0. Outputs become valid on release without needing a clock edge.
- Priority per rising edge: reset > flush > stall > load.
  - flush=1: ex_valid, ex_reg_write, ex_illegal are 0; alu_func=0; data registers may keep their values. Flush wins when stall is also asserted.
  - stall=1: every EX register holds.
  - Otherwise: load from ID.
  - id_valid=0 loads a bubble, identical to flush.
- Latency: one cycle from ID inputs to alu_func/ex_*; alu_a/alu_b are combinational on the registered values plus forwarding inputs.
- Func decode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLT, 6 = illegal (ALU outputs 0).
  - opcode 00h, by funct:
    - 20h ADD, 22h SUB, 24h AND, 25h OR, 27h NOR, 2Ah SLT
    - other funct: func 6, ex_illegal=1
    - ex_reg_write=1, dest=rd
  - 08h addi: ADD; 0Ah slti: SLT; 0Ch andi: AND; 0Dh ori: OR. All have ex_reg_write=1, dest=rt.
  - 23h lw: ADD, ex_reg_write=1, dest=rt.
  - 2Bh sw: ADD, ex_reg_write=0.
  - 04h beq: SUB, ex_reg_write=0. The ALU zero flag resolves the branch downstream.
  - any other opcode: func 6, ex_illegal=1, ex_reg_write=0.
  - Writes to register 0: ex_reg_write is forced to 0 when dest==0.
- Immediate extension:
  - andi/ori: zero-extend imm to size bits.
  - addi/slti/lw/sw/beq: sign-extend.
  - Stored in a registered ex_imm. Operand b uses the immediate for every I-type except beq; beq uses forwarded rt.
- Forwarding, computed separately for rs (→ alu_a) and rt (→ alu_b / ex_store_data):
  - Select exmem_result if exmem_reg_write && exmem_rd!=0 && exmem_rd==ex_rs.
  - Else select memwb_result if memwb_reg_write && memwb_rd!=0 && memwb_rd==ex_rs.
  - Else use the registered register-file data.
  - EX/MEM has priority over MEM/WB when both match.
- Bubbles: when ex_valid=0, alu_a/alu_b still follow the registered values. Downstream ignores the result because ex_valid=0.

Decomposition:
- Shared package mips_defs:
  - ALU func constants ALU_ADD..ALU_SLT, ALU_BAD=6
  - opcode constants OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT
- Natural sub-module: fwd_mux. It is combinational, takes one register index plus the two forwarding sources, and returns the selected value. It is instantiated twice.
- Opcode/funct decode stays inline as a function.

Test Plan:
- Reset mid-operation: load add $3,$1,$2 (rs_data=5, rt_data=7), then assert rst_n=0 between edges → ex_valid=0, alu_func=0 and ex_reg_write=0 immediately.
- R-type decode: opcode 00h, funct 2Ah, rs_data=FFFF_FFFE, rt_data=1, no forwarding → next cycle alu_func=5, alu_a=FFFF_FFFE, alu_b=1, ex_dest=rd, ex_reg_write=1.
- Immediate extension: andi with imm=8000h → alu_b=0000_8000. addi with imm=8000h → alu_b=FFFF_8000, alu_func=0.
- Forward priority: EX holds rs=4; exmem_rd=4 with result AAAA_0000 and memwb_rd=4 with result 5555_0000, both write-enabled → alu_a=AAAA_0000. Deassert exmem_reg_write → alu_a=5555_0000. Set memwb_rd=0 → alu_a=registered rs_data.
- Stall/flush: stall=1 for 2 cycles while ID changes → EX outputs unchanged. stall=1 with flush=1 → ex_valid=0, alu_func=0, ex_reg_write=0.
- Illegal/zero-dest: opcode 3Fh → alu_func=6, ex_illegal=1, ex_reg_write=0. R-type add with rd=0 → ex_reg_write=0, ex_illegal=0.
